// File: rtl/rt_jtag_dtm.sv
// JTAG TAP controller plus RISC-V 0.13 DTM (IDCODE/DTMCS/DMI) issuing DMI requests on TCK.
// Optional RT_DTM_BUSY_CNT_EN adds a 16-bit BUSYCNT DR (IR 0x12) counting busy DMI captures.
module rt_jtag_dtm #(
  parameter int unsigned IrLength = 5,
  parameter logic [31:0] IdCode   = 32'h0000_0001,
  parameter int unsigned AbitsDmi = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  output logic [AbitsDmi-1:0] dmi_req_addr_o,
  output logic [1:0]          dmi_req_op_o,
  output logic [31:0]         dmi_req_data_o,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o,
  input  logic [31:0]         dmi_resp_data_i,
  input  logic [1:0]          dmi_resp_resp_i,
  output logic                dmi_rst_no
);

  localparam int unsigned DrW = AbitsDmi + 34;

  localparam logic [3:0] StTlr     = 4'h0;
  localparam logic [3:0] StIdle    = 4'h1;
  localparam logic [3:0] StSelDr   = 4'h2;
  localparam logic [3:0] StCapDr   = 4'h3;
  localparam logic [3:0] StShiftDr = 4'h4;
  localparam logic [3:0] StExit1Dr = 4'h5;
  localparam logic [3:0] StPauseDr = 4'h6;
  localparam logic [3:0] StExit2Dr = 4'h7;
  localparam logic [3:0] StUpdDr   = 4'h8;
  localparam logic [3:0] StSelIr   = 4'h9;
  localparam logic [3:0] StCapIr   = 4'ha;
  localparam logic [3:0] StShiftIr = 4'hb;
  localparam logic [3:0] StExit1Ir = 4'hc;
  localparam logic [3:0] StPauseIr = 4'hd;
  localparam logic [3:0] StExit2Ir = 4'he;
  localparam logic [3:0] StUpdIr   = 4'hf;

  localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);

  localparam logic [2:0] SelBypass = 3'd0;
  localparam logic [2:0] SelIdcode = 3'd1;
  localparam logic [2:0] SelDtmcs  = 3'd2;
  localparam logic [2:0] SelDmi    = 3'd3;
`ifdef RT_DTM_BUSY_CNT_EN
  localparam logic [IrLength-1:0] IrBusy  = IrLength'(5'h12);
  localparam logic [2:0]          SelBusy = 3'd4;
`endif

  logic [3:0]          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_shift_q;
  logic [DrW-1:0]      dr_q, dr_d;
  logic [2:0]          dr_sel;

  logic [1:0]          sticky_q, sticky_d, sticky_eff;
  logic                pending_q, pending_d, pending_eff;
  logic [31:0]         resp_data_q, resp_data_d, resp_data_eff;
  logic                req_valid_q, req_valid_d;
  logic [AbitsDmi-1:0] req_addr_q, req_addr_d;
  logic [1:0]          req_op_q, req_op_d;
  logic [31:0]         req_data_q, req_data_d;
  logic                rst_n_q, hard_rst;
  logic [1:0]          cap_op, upd_op;
  logic [31:0]         dtmcs_cap;
  logic                dmi_cap, dmi_upd, dtmcs_upd;
`ifdef RT_DTM_BUSY_CNT_EN
  logic [15:0]         busy_cnt_q, busy_cnt_d;
`endif

  // TAP state machine
  always_comb begin
    state_d = StTlr;
    case (state_q)
      StTlr:     state_d = tms_i ? StTlr     : StIdle;
      StIdle:    state_d = tms_i ? StSelDr   : StIdle;
      StSelDr:   state_d = tms_i ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_i ? StExit1Dr : StShiftDr;
      StShiftDr: state_d = tms_i ? StExit1Dr : StShiftDr;
      StExit1Dr: state_d = tms_i ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_i ? StExit2Dr : StPauseDr;
      StExit2Dr: state_d = tms_i ? StUpdDr   : StShiftDr;
      StUpdDr:   state_d = tms_i ? StSelDr   : StIdle;
      StSelIr:   state_d = tms_i ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_i ? StExit1Ir : StShiftIr;
      StShiftIr: state_d = tms_i ? StExit1Ir : StShiftIr;
      StExit1Ir: state_d = tms_i ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_i ? StExit2Ir : StPauseIr;
      StExit2Ir: state_d = tms_i ? StUpdIr   : StShiftIr;
      StUpdIr:   state_d = tms_i ? StSelDr   : StIdle;
      default:   state_d = StTlr;
    endcase
  end

  // Unknown instructions fall back to BYPASS
  always_comb begin
    dr_sel = SelBypass;
    if (ir_q == IrIdcode)      dr_sel = SelIdcode;
    else if (ir_q == IrDtmcs)  dr_sel = SelDtmcs;
    else if (ir_q == IrDmi)    dr_sel = SelDmi;
`ifdef RT_DTM_BUSY_CNT_EN
    else if (ir_q == IrBusy)   dr_sel = SelBusy;
`endif
  end

  // A response arriving this cycle is treated as already completed by capture/update
  always_comb begin
    pending_eff   = dmi_resp_valid_i ? 1'b0 : pending_q;
    resp_data_eff = dmi_resp_valid_i ? dmi_resp_data_i : resp_data_q;
    sticky_eff    = sticky_q;
    if (dmi_resp_valid_i && (dmi_resp_resp_i == 2'd2)) sticky_eff = 2'd2;
    if (dmi_resp_valid_i && (dmi_resp_resp_i == 2'd3)) sticky_eff = 2'd3;
    cap_op    = pending_eff ? 2'd3 : sticky_eff;
    upd_op    = dr_q[1:0];
    dtmcs_cap = {17'b0, 3'd1, sticky_eff, 6'(AbitsDmi), 4'd1};
    dmi_cap   = (state_q == StCapDr) && (dr_sel == SelDmi);
    dmi_upd   = (state_q == StUpdDr) && (dr_sel == SelDmi);
    dtmcs_upd = (state_q == StUpdDr) && (dr_sel == SelDtmcs);
  end

  always_comb begin
    dr_d = dr_q;
    if (state_q == StCapDr) begin
      case (dr_sel)
        SelIdcode: dr_d = DrW'(IdCode);
        SelDtmcs:  dr_d = DrW'(dtmcs_cap);
        SelDmi:    dr_d = {req_addr_q, resp_data_eff, cap_op};
`ifdef RT_DTM_BUSY_CNT_EN
        SelBusy:   dr_d = DrW'(busy_cnt_q);
`endif
        default:   dr_d = '0;
      endcase
    end else if (state_q == StShiftDr) begin
      case (dr_sel)
        SelIdcode, SelDtmcs: dr_d = DrW'({tdi_i, dr_q[31:1]});
        SelDmi:              dr_d = {tdi_i, dr_q[DrW-1:1]};
`ifdef RT_DTM_BUSY_CNT_EN
        SelBusy:             dr_d = DrW'({tdi_i, dr_q[15:1]});
`endif
        default:             dr_d = DrW'(tdi_i);
      endcase
    end
  end

  // DMI request / response bookkeeping
  always_comb begin
    sticky_d    = sticky_eff;
    pending_d   = pending_eff;
    resp_data_d = resp_data_eff;
    req_valid_d = req_valid_q && !dmi_req_ready_i;
    req_addr_d  = req_addr_q;
    req_op_d    = req_op_q;
    req_data_d  = req_data_q;
    hard_rst    = 1'b0;
    if (dmi_cap && pending_eff) sticky_d = 2'd3;
    if (dmi_upd) begin
      if (pending_eff) begin
        sticky_d = 2'd3;
      end else if ((sticky_eff == 2'd0) && ((upd_op == 2'd1) || (upd_op == 2'd2))) begin
        req_valid_d = 1'b1;
        req_addr_d  = dr_q[DrW-1:34];
        req_data_d  = dr_q[33:2];
        req_op_d    = upd_op;
        pending_d   = 1'b1;
      end
    end
    if (dtmcs_upd && dr_q[16]) sticky_d = 2'd0;
    // Hardreset overrides any response landing in the same cycle
    if (dtmcs_upd && dr_q[17]) begin
      sticky_d    = 2'd0;
      pending_d   = 1'b0;
      req_valid_d = 1'b0;
      hard_rst    = 1'b1;
    end
  end

`ifdef RT_DTM_BUSY_CNT_EN
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (dmi_cap && (cap_op == 2'd3) && (busy_cnt_q != 16'hffff)) busy_cnt_d = busy_cnt_q + 16'd1;
    if ((state_q == StUpdDr) && (dr_sel == SelBusy)) busy_cnt_d = '0;
    if (hard_rst) busy_cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_cnt_q <= '0;
    else         busy_cnt_q <= busy_cnt_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StTlr;
      ir_q        <= IrIdcode;
      ir_shift_q  <= '0;
      dr_q        <= '0;
      sticky_q    <= '0;
      pending_q   <= 1'b0;
      resp_data_q <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_op_q    <= '0;
      req_data_q  <= '0;
      rst_n_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == StTlr)        ir_q <= IrIdcode;
      else if (state_q == StUpdIr) ir_q <= ir_shift_q;
      if (state_q == StCapIr)        ir_shift_q <= IrLength'(1);
      else if (state_q == StShiftIr) ir_shift_q <= {tdi_i, ir_shift_q[IrLength-1:1]};
      dr_q        <= dr_d;
      sticky_q    <= sticky_d;
      pending_q   <= pending_d;
      resp_data_q <= resp_data_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_op_q    <= req_op_d;
      req_data_q  <= req_data_d;
      rst_n_q     <= !hard_rst;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= (state_q == StShiftDr) || (state_q == StShiftIr);
      if (state_q == StShiftIr)      tdo_o <= ir_shift_q[0];
      else if (state_q == StShiftDr) tdo_o <= dr_q[0];
      else                           tdo_o <= 1'b0;
    end
  end

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_op_o     = req_op_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_resp_ready_o = 1'b1;
  assign dmi_rst_no       = rst_n_q;

endmodule

// File: tb/tb_rt_jtag_dtm.sv
// Directed bench for rt_jtag_dtm: drives the JTAG pins and plays the DMI responder.
module tb_rt_jtag_dtm;

  localparam logic [31:0] IdCodeTb = 32'h4BA0_0477;

  logic        clk_i = 1'b0;
  logic        rst_ni, tms_i, tdi_i;
  logic        tdo_o, tdo_oe_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_resp_i;
  logic        dmi_rst_no;

  int checks = 0;
  int errors = 0;
  logic [63:0] out;
  logic [4:0]  ir_out;

  rt_jtag_dtm #(
    .IrLength(5),
    .IdCode  (IdCodeTb),
    .AbitsDmi(7)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .tms_i           (tms_i),
    .tdi_i           (tdi_i),
    .tdo_o           (tdo_o),
    .tdo_oe_o        (tdo_oe_o),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_req_addr_o  (dmi_req_addr_o),
    .dmi_req_op_o    (dmi_req_op_o),
    .dmi_req_data_o  (dmi_req_data_o),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i (dmi_resp_data_i),
    .dmi_resp_resp_i (dmi_resp_resp_i),
    .dmi_rst_no      (dmi_rst_no)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK: inputs set after negedge, state advances on posedge, back to negedge+1
  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  task automatic reset_tap();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle back to Run-Test/Idle
  task automatic shift_ir(input logic [4:0] v, output logic [4:0] o);
    o = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) chk("oe_shift_ir", 64'(tdo_oe_o), 64'd1);
      o[i] = tdo_o;
      step(i == 4, v[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input logic [63:0] v, input int n, output logic [63:0] o);
    o = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      o[i] = tdo_o;
      step(i == n - 1, v[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = d;
    dmi_resp_resp_i  = r;
    step(1'b0, 1'b0);
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_resp_i  = '0;
  endtask

  initial begin
    rst_ni = 1'b0; tms_i = 1'b1; tdi_i = 1'b0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i = '0; dmi_resp_resp_i = '0;
    #12;
    chk("rst_tdo", {62'b0, tdo_oe_o, tdo_o}, 64'd0);
    chk("rst_req", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, 64'd0);
    chk("rst_rstn_respready", {62'b0, dmi_rst_no, dmi_resp_ready_o}, 64'd3);
    rst_ni = 1'b1;

    // IDCODE selected after reset, then IR capture and DTMCS
    reset_tap();
    chk("oe_idle", 64'(tdo_oe_o), 64'd0);
    shift_dr(64'd0, 32, out);
    chk("idcode", out, 64'(IdCodeTb));
    shift_ir(5'h10, ir_out);
    chk("ir_capture", 64'(ir_out), 64'd1);
    shift_dr(64'd0, 32, out);
    chk("dtmcs", out, 64'h0000_1071);

    // DMI write with ready held low three cycles
    shift_ir(5'h11, ir_out);
    shift_dr(dmi(7'h10, 32'h1, 2'd2), 41, out);
    chk("dmi_cap0", out, 64'd0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmi_req_ready_i = 1'b1;
      chk("wr_hold", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o},
          {1'b1, 7'h10, 2'd2, 32'h1});
      step(1'b0, 1'b0);
    end
    chk("wr_done", 64'(dmi_req_valid_o), 64'd0);
    respond(32'h0, 2'd0);
    shift_dr(64'd0, 41, out);
    chk("wr_cap", out, dmi(7'h10, 32'h0, 2'd0));

    // DMI read
    shift_dr(dmi(7'h11, 32'h0, 2'd1), 41, out);
    chk("rd_req", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o}, {1'b1, 7'h11, 2'd1});
    step(1'b0, 1'b0);
    chk("rd_acc", 64'(dmi_req_valid_o), 64'd0);
    respond(32'hDEAD_BEEF, 2'd0);
    shift_dr(64'd0, 41, out);
    chk("rd_cap", out, dmi(7'h11, 32'hDEAD_BEEF, 2'd0));

    // Busy: capture while pending, ignored update, dmistat, dmireset
    shift_dr(dmi(7'h20, 32'h55, 2'd2), 41, out);
    step(1'b0, 1'b0);
    shift_dr(dmi(7'h21, 32'h66, 2'd2), 41, out);
    chk("busy_cap", out, dmi(7'h20, 32'hDEAD_BEEF, 2'd3));
    chk("busy_ignored", {dmi_req_valid_o, dmi_req_addr_o}, {1'b0, 7'h20});
    shift_ir(5'h10, ir_out);
    shift_dr(64'h1_0000, 32, out);
    chk("dmistat_busy", out, 64'h0000_1C71);
    shift_dr(64'd0, 32, out);
    chk("dmistat_clr", out, 64'h0000_1071);
    respond(32'h0, 2'd0);

    // dmihardreset while a request is still held
    dmi_req_ready_i = 1'b0;
    shift_ir(5'h11, ir_out);
    shift_dr(dmi(7'h30, 32'h77, 2'd2), 41, out);
    chk("hr_cap", out, dmi(7'h20, 32'h0, 2'd0));
    shift_ir(5'h10, ir_out);
    chk("hr_valid_before", 64'(dmi_req_valid_o), 64'd1);
    shift_dr(64'h2_0000, 32, out);
    chk("hr_pulse", {62'b0, dmi_rst_no, dmi_req_valid_o}, 64'd0);
    step(1'b0, 1'b0);
    chk("hr_pulse_end", {62'b0, dmi_rst_no, dmi_req_valid_o}, 64'd2);
    shift_ir(5'h11, ir_out);
    shift_dr(64'd0, 41, out);
    chk("hr_pend_clr", out, dmi(7'h30, 32'h0, 2'd0));

`ifdef RT_DTM_BUSY_CNT_EN
    dmi_req_ready_i = 1'b1;
    shift_dr(dmi(7'h40, 32'h0, 2'd1), 41, out);
    step(1'b0, 1'b0);
    shift_dr(64'd0, 41, out);
    chk("bc_cap1", out, dmi(7'h40, 32'h0, 2'd3));
    shift_dr(64'd0, 41, out);
    shift_ir(5'h12, ir_out);
    shift_dr(64'd0, 16, out);
    chk("busycnt", out, 64'd2);
    shift_dr(64'd0, 16, out);
    chk("busycnt_clr", out, 64'd0);
    respond(32'h0, 2'd0);
    shift_ir(5'h10, ir_out);
    shift_dr(64'h1_0000, 32, out);
    chk("bc_dmistat", out, 64'h0000_1C71);
`else
    shift_ir(5'h12, ir_out);
    shift_dr(64'd1, 2, out);
    chk("ir12_bypass", out, 64'd2);
`endif
    shift_ir(5'h1F, ir_out);
    shift_dr(64'd1, 2, out);
    chk("bypass", out, 64'd2);
    shift_ir(5'h05, ir_out);
    shift_dr(64'd1, 2, out);
    chk("unknown_bypass", out, 64'd2);

    // Five TMS=1 from the middle of Shift-DR forces IR back to IDCODE
    shift_ir(5'h10, ir_out);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    reset_tap();
    shift_dr(64'd0, 32, out);
    chk("tlr_idcode", out, 64'(IdCodeTb));

    // Async reset in the middle of a held request
    dmi_req_ready_i = 1'b0;
    shift_ir(5'h11, ir_out);
    shift_dr(dmi(7'h50, 32'h99, 2'd2), 41, out);
    chk("ar_valid", 64'(dmi_req_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_abort", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, 64'd0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    dmi_req_ready_i = 1'b1;
    reset_tap();
    chk("ar_no_reissue", {62'b0, dmi_rst_no, dmi_req_valid_o}, 64'd2);
    shift_dr(64'd0, 32, out);
    chk("ar_idcode", out, 64'(IdCodeTb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
